diag_entry_ctrl: RTL and testbench

DIAG_ENTRY_CTRL -- requirements
Module: diag_entry_ctrl

---
 rtl/diag_pkg.sv | 31 +++
 rtl/diag_entry_ctrl_bcd_accum.sv | 72 +++++++
 rtl/diag_entry_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_diag_entry_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// ---------------------------------------------------------------------------
// diag_pkg
//   Shared types and constants for the diagnostic entry controller.
//   - state_t      : controller FSM states
//   - BCD_W        : width of one BCD display/entry digit
//   - NUM_KEYS     : keypad lines (digits 0..9)
//   - DEF_THRESH   : default per-field hit thresholds (field 0 in LSBs)
//   - DEF_MIN_HITS : default hit count at which the outcome asserts
// ---------------------------------------------------------------------------
package diag_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EVAL    = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  localparam int BCD_W          = 4;
  localparam int NUM_KEYS       = 10;
  localparam int DEF_NUM_FIELDS = 7;
  localparam int DEF_VAL_W      = 14;

  // Field order: pregnancies, glucose, blood pressure, skin, insulin, BMI, age.
  localparam logic [DEF_NUM_FIELDS*DEF_VAL_W-1:0] DEF_THRESH = {
    14'd50, 14'd30, 14'd200, 14'd35, 14'd90, 14'd140, 14'd6
  };

  localparam int DEF_MIN_HITS = 3;

endpackage

// File: rtl/diag_entry_ctrl_bcd_accum.sv
// ---------------------------------------------------------------------------
// bcd_accum
//   Serial BCD-to-binary converter. A start pulse captures the BCD word;
//   each following cycle folds in one digit, most significant first
//   (acc = acc*10 + digit). After NUM_DIGITS steps o_done pulses for one
//   cycle with o_value holding the result.
//   Ports:
//     clk, reset_n  : clock, async active-low reset
//     i_start       : capture i_digits and begin conversion
//     i_abort       : drop any conversion in flight (sync)
//     i_digits      : BCD word, digit 0 in LSBs
//     o_done        : one-cycle pulse, o_value valid
//     o_value       : converted binary value
// ---------------------------------------------------------------------------
module bcd_accum
  import diag_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [BCD_W*NUM_DIGITS-1:0]   i_digits,
  output logic                          o_done,
  output logic [VAL_W-1:0]              o_value
);

  localparam int CNT_W = $clog2(NUM_DIGITS+1);

  logic [BCD_W*NUM_DIGITS-1:0] r_shift;
  logic [VAL_W-1:0]            r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_done;

  logic [BCD_W-1:0]            w_top;
  logic [VAL_W-1:0]            w_acc_nxt;

  assign w_top     = r_shift[BCD_W*NUM_DIGITS-1 -: BCD_W];
  assign w_acc_nxt = (r_acc * VAL_W'(10)) + VAL_W'(w_top);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_digits;
      r_acc   <= '0;
      r_cnt   <= CNT_W'(NUM_DIGITS);
      r_done  <= 1'b0;
    end else if (r_cnt != '0) begin
      r_acc   <= w_acc_nxt;
      r_shift <= r_shift << BCD_W;
      r_cnt   <= r_cnt - CNT_W'(1);
      r_done  <= (r_cnt == CNT_W'(1));
    end else begin
      r_done  <= 1'b0;
    end
  end

  assign o_done  = r_done;
  assign o_value = r_acc;

endmodule

// File: rtl/diag_entry_ctrl.sv
// ---------------------------------------------------------------------------
// diag_entry_ctrl
//   Keypad entry controller for a fixed-length diagnostic record. Digits are
//   typed into a BCD buffer, committed per field with 'next', converted to
//   binary serially, and once all fields are in, each is compared against
//   its threshold to produce a hit count and an outcome flag.
//   Ports:
//     clk, reset_n   : clock, async active-low reset
//     key[9:0]       : raw keypad levels, bit n = digit n
//     del, next      : backspace / commit (restart when in RESULT) levels
//     clear          : abort the record
//     field_idx      : field being entered; NUM_FIELDS in RESULT
//     disp_digits    : BCD display (entry buffer, or hit count in RESULT)
//     digit_count    : digits held in entry buffer
//     busy           : converting or evaluating
//     overflow       : one-cycle pulse on a key into a full buffer
//     result_valid   : record evaluated
//     outcome        : hit_count >= MIN_HITS (in RESULT)
//     hit_count      : fields at or above threshold
// ---------------------------------------------------------------------------
module diag_entry_ctrl
  import diag_pkg::*;
#(
  parameter int                          NUM_FIELDS = 7,
  parameter int                          NUM_DIGITS = 4,
  parameter int                          VAL_W      = 14,
  parameter logic [NUM_FIELDS*VAL_W-1:0] THRESH     = DEF_THRESH,
  parameter int                          MIN_HITS   = DEF_MIN_HITS
)(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_KEYS-1:0]                  key,
  input  logic                                 del,
  input  logic                                 next,
  input  logic                                 clear,
  output logic [$clog2(NUM_FIELDS+1)-1:0]      field_idx,
  output logic [BCD_W*NUM_DIGITS-1:0]          disp_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count,
  output logic                                 busy,
  output logic                                 overflow,
  output logic                                 result_valid,
  output logic                                 outcome,
  output logic [3:0]                           hit_count
);

  localparam int FI_W  = $clog2(NUM_FIELDS+1);
  localparam int DC_W  = $clog2(NUM_DIGITS+1);
  localparam int BUF_W = BCD_W*NUM_DIGITS;

  // ---- state ----
  state_t                             r_state, w_state_nxt;
  logic [FI_W-1:0]                    r_field_idx;
  logic [FI_W-1:0]                    r_eval_idx;
  logic [BUF_W-1:0]                   r_buf;
  logic [DC_W-1:0]                    r_dcnt;
  logic [NUM_FIELDS-1:0][VAL_W-1:0]   r_vals;
  logic [3:0]                         r_hits;
  logic                               r_overflow;

  // Edge detect: previous samples plus an arm bit. The arm bit keeps levels
  // already high when reset releases from looking like fresh edges.
  logic r_arm, r_key_prev, r_del_prev, r_next_prev, r_clr_prev;
  logic w_key_e, w_del_e, w_next_e, w_clr_e;

  assign w_key_e  = r_arm & (|key) & ~r_key_prev;
  assign w_del_e  = r_arm & del    & ~r_del_prev;
  assign w_next_e = r_arm & next   & ~r_next_prev;
  assign w_clr_e  = r_arm & clear  & ~r_clr_prev;

  // Lowest set key wins when several rise together.
  logic [BCD_W-1:0] w_digit;
  always_comb begin
    w_digit = '0;
    for (int i = NUM_KEYS-1; i >= 0; i--)
      if (key[i]) w_digit = BCD_W'(i);
  end

  logic [BUF_W-1:0] w_buf_up;
  always_comb begin
    w_buf_up = r_buf << BCD_W;
    w_buf_up[BCD_W-1:0] = w_digit;
  end

  // ---- converter ----
  logic             w_start, w_acc_done;
  logic [VAL_W-1:0] w_acc_val;
  logic             w_clr;

  bcd_accum #(
    .NUM_DIGITS (NUM_DIGITS),
    .VAL_W      (VAL_W)
  ) u_bcd_accum (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_start),
    .i_abort  (w_clr),
    .i_digits (r_buf),
    .o_done   (w_acc_done),
    .o_value  (w_acc_val)
  );

  // ---- evaluation ----
  logic [NUM_FIELDS-1:0][VAL_W-1:0] w_thr;
  logic w_hit, w_last, w_eval_last;

  assign w_thr       = THRESH;
  assign w_hit       = (r_vals[r_eval_idx] >= w_thr[r_eval_idx]);
  assign w_last      = (r_field_idx == FI_W'(NUM_FIELDS-1));
  assign w_eval_last = (r_eval_idx  == FI_W'(NUM_FIELDS-1));

  // ---- FSM ----
  logic w_key, w_del, w_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ENTRY;
    else          r_state <= w_state_nxt;
  end

  // Priority clear > next > del > key; only the winner is acted on.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_start     = 1'b0;
    w_key       = 1'b0;
    w_del       = 1'b0;
    w_ovf       = 1'b0;
    if (w_clr_e) begin
      w_state_nxt = ST_ENTRY;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        ST_ENTRY: begin
          if (w_next_e) begin
            w_state_nxt = ST_CONVERT;
            w_start     = 1'b1;
          end else if (w_del_e) begin
            w_del = (r_dcnt != '0);
          end else if (w_key_e) begin
            if (r_dcnt == DC_W'(NUM_DIGITS)) w_ovf = 1'b1;
            else                             w_key = 1'b1;
          end
        end
        ST_CONVERT: begin
          if (w_acc_done) w_state_nxt = w_last ? ST_EVAL : ST_ENTRY;
        end
        ST_EVAL: begin
          if (w_eval_last) w_state_nxt = ST_RESULT;
        end
        ST_RESULT: begin
          // Restart is the same full clear as an abort.
          if (w_next_e) begin
            w_state_nxt = ST_ENTRY;
            w_clr       = 1'b1;
          end
        end
        default: w_state_nxt = ST_ENTRY;
      endcase
    end
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm       <= 1'b0;
      r_key_prev  <= 1'b0;
      r_del_prev  <= 1'b0;
      r_next_prev <= 1'b0;
      r_clr_prev  <= 1'b0;
      r_overflow  <= 1'b0;
      r_field_idx <= '0;
      r_eval_idx  <= '0;
      r_buf       <= '0;
      r_dcnt      <= '0;
      r_vals      <= '0;
      r_hits      <= '0;
    end else begin
      r_arm       <= 1'b1;
      r_key_prev  <= |key;
      r_del_prev  <= del;
      r_next_prev <= next;
      r_clr_prev  <= clear;
      r_overflow  <= w_ovf;
      if (w_clr) begin
        r_field_idx <= '0;
        r_eval_idx  <= '0;
        r_buf       <= '0;
        r_dcnt      <= '0;
        r_vals      <= '0;
        r_hits      <= '0;
      end else begin
        unique case (r_state)
          ST_ENTRY: begin
            if (w_key) begin
              r_buf  <= w_buf_up;
              r_dcnt <= r_dcnt + DC_W'(1);
            end else if (w_del) begin
              r_buf  <= r_buf >> BCD_W;
              r_dcnt <= r_dcnt - DC_W'(1);
            end
          end
          ST_CONVERT: begin
            if (w_acc_done) begin
              r_vals[r_field_idx] <= w_acc_val;
              if (w_last) begin
                r_eval_idx <= '0;
                r_hits     <= '0;
              end else begin
                r_field_idx <= r_field_idx + FI_W'(1);
                r_buf       <= '0;
                r_dcnt      <= '0;
              end
            end
          end
          ST_EVAL: begin
            if (w_hit) r_hits <= r_hits + 4'd1;
            r_eval_idx <= r_eval_idx + FI_W'(1);
            if (w_eval_last) r_field_idx <= FI_W'(NUM_FIELDS);
          end
          default: ;
        endcase
      end
    end
  end

  // ---- outputs ----
  logic [BUF_W-1:0] w_disp;
  always_comb begin
    w_disp = r_buf;
    if (r_state == ST_RESULT) begin
      w_disp = '0;
      w_disp[BCD_W-1:0] = r_hits;
    end
  end

  assign field_idx    = r_field_idx;
  assign disp_digits  = w_disp;
  assign digit_count  = r_dcnt;
  assign busy         = (r_state == ST_CONVERT) || (r_state == ST_EVAL);
  assign overflow     = r_overflow;
  assign result_valid = (r_state == ST_RESULT);
  assign outcome      = result_valid && (int'(r_hits) >= MIN_HITS);
  assign hit_count    = r_hits;

endmodule

// File: tb/tb_diag_entry_ctrl.sv
module tb_diag_entry_ctrl;
  localparam int NF = 7;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  key = '0;
  logic        del = 1'b0, next = 1'b0, clear = 1'b0;
  logic [2:0]  field_idx;
  logic [15:0] disp_digits;
  logic [2:0]  digit_count;
  logic        busy, overflow, result_valid, outcome;
  logic [3:0]  hit_count;

  int checks = 0;
  int failures = 0;
  int thr[NF] = '{6, 140, 90, 35, 200, 30, 50};

  always #5 clk = ~clk;

  diag_entry_ctrl dut (
    .clk(clk), .reset_n(reset_n), .key(key), .del(del), .next(next), .clear(clear),
    .field_idx(field_idx), .disp_digits(disp_digits), .digit_count(digit_count),
    .busy(busy), .overflow(overflow), .result_valid(result_valid),
    .outcome(outcome), .hit_count(hit_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [15:0] pack_q(input int q[$]);
    logic [15:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[4*i +: 4] = 4'(q[i]);
    return r;
  endfunction

  function automatic int model_hits(input int v[NF]);
    int h = 0;
    for (int i = 0; i < NF; i++) if (v[i] >= thr[i]) h++;
    return h;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic press_raw(input logic [9:0] k);
    @(negedge clk); key = k;
    @(negedge clk); key = '0;
  endtask

  task automatic press_key(input int d);
    logic [9:0] k;
    k = '0;
    k[d] = 1'b1;
    press_raw(k);
  endtask

  task automatic press_del();
    @(negedge clk); del = 1'b1;
    @(negedge clk); del = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic type_value(input int v);
    int d[$];
    int t;
    t = v;
    do begin d.push_front(t % 10); t = t / 10; end while (t > 0);
    foreach (d[i]) press_key(d[i]);
  endtask

  // Returns edges after the commit edge until done (-1 on timeout).
  task automatic commit(output int lat, input bit want_result);
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (want_result ? (result_valid === 1'b1) : (busy === 1'b0)) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic enter_record(input int v[NF], output int lats[NF], output int fis[NF]);
    int l;
    for (int i = 0; i < NF; i++) begin
      type_value(v[i]);
      commit(l, i == NF-1);
      lats[i] = l;
      fis[i]  = int'(field_idx);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; key = 10'h008; del = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({field_idx, disp_digits, digit_count} !== 22'd0) begin failures++;
      $display("FAIL reset_regs: got fi=%0d disp=%h dc=%0d want 0/0/0", field_idx, disp_digits, digit_count); end
    checks++; if ({busy, overflow, result_valid, outcome, hit_count} !== 8'd0) begin failures++;
      $display("FAIL reset_flags: got %b want 0", {busy, overflow, result_valid, outcome, hit_count}); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (digit_count !== 3'd0 || disp_digits !== 16'h0) begin failures++;
      $display("FAIL held_at_release: got dc=%0d disp=%h want 0/0000", digit_count, disp_digits); end
    key = '0; del = 1'b0;
    press_key(2);
    checks++; if (digit_count !== 3'd1 || disp_digits !== 16'h0002) begin failures++;
      $display("FAIL first_key: got dc=%0d disp=%h want 1/0002", digit_count, disp_digits); end
    @(posedge clk); #2 reset_n = 1'b0; #1;
    checks++; if (digit_count !== 3'd0 || disp_digits !== 16'h0) begin failures++;
      $display("FAIL async_reset: got dc=%0d disp=%h want 0/0000", digit_count, disp_digits); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry_del();
    press_del();
    checks++; if (digit_count !== 3'd0) begin failures++;
      $display("FAIL del_at_zero: got %0d want 0", digit_count); end
    press_key(1); press_key(4); press_key(0); press_del(); press_key(5);
    checks++; if (disp_digits !== 16'h0145 || digit_count !== 3'd3) begin failures++;
      $display("FAIL entry_del: got disp=%h dc=%0d want 0145/3", disp_digits, digit_count); end
  endtask

  task automatic test_overflow();
    int ds[5] = '{9, 8, 7, 6, 5};
    press_clear();
    for (int i = 0; i < 5; i++) begin
      press_key(ds[i]);
      checks++; if (overflow !== (i == 4)) begin failures++;
        $display("FAIL overflow_press%0d: got %b want %b", i, overflow, (i == 4)); end
    end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin failures++;
      $display("FAIL overflow_pulse_width: got %b want 0", overflow); end
    checks++; if (disp_digits !== 16'h9876 || digit_count !== 3'd4) begin failures++;
      $display("FAIL overflow_buf: got disp=%h dc=%0d want 9876/4", disp_digits, digit_count); end
  endtask

  task automatic test_random_entry();
    int q[$];
    bit exp_ovf;
    int d;
    press_clear();
    for (int n = 0; n < 40; n++) begin
      exp_ovf = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        press_del();
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        d = $urandom_range(0, 9);
        press_key(d);
        if (q.size() < ND) q.push_front(d); else exp_ovf = 1'b1;
      end
      checks++; if (disp_digits !== pack_q(q) || int'(digit_count) != q.size() || overflow !== exp_ovf) begin
        failures++;
        $display("FAIL rand_entry op%0d: got disp=%h dc=%0d ovf=%b want %h/%0d/%b",
                 n, disp_digits, digit_count, overflow, pack_q(q), q.size(), exp_ovf);
      end
    end
  endtask

  task automatic test_next_key_same();
    press_clear();
    press_key(3);
    @(negedge clk); next = 1'b1; key = 10'h080;
    @(negedge clk); next = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL nk_commit_busy: got %b want 1", busy); end
    repeat (ND+1) @(negedge clk);
    checks++; if (busy !== 1'b0 || field_idx !== 3'd1 || digit_count !== 3'd0) begin failures++;
      $display("FAIL nk_commit_done: got busy=%b fi=%0d dc=%0d want 0/1/0", busy, field_idx, digit_count); end
    repeat (13) @(negedge clk);
    checks++; if (digit_count !== 3'd0) begin failures++;
      $display("FAIL nk_held_key: got dc=%0d want 0", digit_count); end
    key = '0; @(negedge clk);
    key = 10'h020;
    repeat (20) @(negedge clk);
    key = '0; @(negedge clk);
    checks++; if (digit_count !== 3'd1 || disp_digits !== 16'h0005) begin failures++;
      $display("FAIL held_one_digit: got dc=%0d disp=%h want 1/0005", digit_count, disp_digits); end
    press_raw(10'b0001010000);
    checks++; if (digit_count !== 3'd2 || disp_digits !== 16'h0054) begin failures++;
      $display("FAIL lowest_key: got dc=%0d disp=%h want 2/0054", digit_count, disp_digits); end
  endtask

  task automatic test_clear_mid_convert();
    int l;
    int pre[3] = '{5, 160, 95};
    press_clear();
    for (int i = 0; i < 3; i++) begin type_value(pre[i]); commit(l, 1'b0); end
    checks++; if (field_idx !== 3'd3) begin failures++;
      $display("FAIL clr_setup_field: got %0d want 3", field_idx); end
    type_value(36);
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL clr_mid_busy: got %b want 1", busy); end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (busy !== 1'b0 || field_idx !== 3'd0 || digit_count !== 3'd0 || disp_digits !== 16'h0) begin
      failures++;
      $display("FAIL clr_mid_convert: got busy=%b fi=%0d dc=%0d disp=%h want 0/0/0/0000",
               busy, field_idx, digit_count, disp_digits);
    end
    repeat (ND+2) @(negedge clk);
    checks++; if (busy !== 1'b0 || field_idx !== 3'd0) begin failures++;
      $display("FAIL clr_no_stray_store: got busy=%b fi=%0d want 0/0", busy, field_idx); end
    type_value(12);
    @(negedge clk); next = 1'b1; clear = 1'b1;
    @(negedge clk); next = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0 || digit_count !== 3'd0 || field_idx !== 3'd0) begin failures++;
      $display("FAIL clr_beats_next: got busy=%b dc=%0d fi=%0d want 0/0/0", busy, digit_count, field_idx); end
  endtask

  task automatic test_record_hit();
    int v[NF] = '{2, 150, 70, 40, 250, 33, 45};
    int lats[NF], fis[NF];
    press_clear();
    enter_record(v, lats, fis);
    for (int i = 0; i < NF; i++) begin
      checks++; if (lats[i] != ((i == NF-1) ? 1+ND+NF : 1+ND) || fis[i] != i+1) begin failures++;
        $display("FAIL hit_field%0d: got lat=%0d fi=%0d want %0d/%0d",
                 i, lats[i], fis[i], (i == NF-1) ? 1+ND+NF : 1+ND, i+1); end
    end
    checks++; if (hit_count !== 4'd4 || outcome !== 1'b1 || disp_digits !== 16'h0004) begin failures++;
      $display("FAIL hit_result: got hits=%0d out=%b disp=%h want 4/1/0004", hit_count, outcome, disp_digits); end
    checks++; if (busy !== 1'b0 || result_valid !== 1'b1) begin failures++;
      $display("FAIL hit_flags: got busy=%b rv=%b want 0/1", busy, result_valid); end
  endtask

  task automatic test_record_miss();
    int v[NF] = '{1, 100, 60, 20, 80, 22, 30};
    int lats[NF], fis[NF];
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    checks++; if ({field_idx, result_valid, hit_count, outcome, disp_digits, digit_count} !== 27'd0) begin
      failures++;
      $display("FAIL restart_clear1: got fi=%0d rv=%b hits=%0d out=%b disp=%h dc=%0d want all 0",
               field_idx, result_valid, hit_count, outcome, disp_digits, digit_count);
    end
    enter_record(v, lats, fis);
    checks++; if (result_valid !== 1'b1 || hit_count !== 4'd0 || outcome !== 1'b0 || field_idx !== 3'd7) begin
      failures++;
      $display("FAIL miss_result: got rv=%b hits=%0d out=%b fi=%0d want 1/0/0/7",
               result_valid, hit_count, outcome, field_idx);
    end
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    checks++; if ({field_idx, result_valid, hit_count, outcome, busy} !== 10'd0) begin failures++;
      $display("FAIL restart_clear2: got fi=%0d rv=%b hits=%0d out=%b busy=%b want all 0",
               field_idx, result_valid, hit_count, outcome, busy); end
  endtask

  task automatic test_random_records();
    int v[NF], lats[NF], fis[NF];
    int h, hi;
    for (int r = 0; r < 4; r++) begin
      press_clear();
      for (int i = 0; i < NF; i++) begin
        hi = 2*thr[i] + 5;
        v[i] = $urandom_range(0, hi);
      end
      enter_record(v, lats, fis);
      h = model_hits(v);
      checks++; if (int'(hit_count) != h || outcome !== (h >= 3) || disp_digits !== 16'(h)) begin
        failures++;
        $display("FAIL rand_rec%0d: got hits=%0d out=%b disp=%h want %0d/%b/%h",
                 r, hit_count, outcome, disp_digits, h, (h >= 3), 16'(h));
      end
      checks++; if (lats[NF-1] != 1+ND+NF || fis[NF-1] != NF) begin failures++;
        $display("FAIL rand_rec%0d_lat: got lat=%0d fi=%0d want %0d/%0d", r, lats[NF-1], fis[NF-1], 1+ND+NF, NF); end
    end
  endtask

  initial begin
    test_reset();
    test_entry_del();
    test_overflow();
    test_random_entry();
    test_next_key_same();
    test_clear_mid_convert();
    test_record_hit();
    test_record_miss();
    test_random_records();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
